// File: rtl/sync_fifo_8_if.sv
// ============================================================================
// Module      : sync_fifo_8_if
// Description : Push/pop handshake bundle for the single-clock byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_8_if;
  logic       cke;
  logic [7:0] data;
  logic       cke_o;
  logic [7:0] data_o;
  logic [1:0] status;

  modport master (
    output cke,
    output data,
    output cke_o,
    input  data_o,
    input  status
  );

  modport slave (
    input  cke,
    input  data,
    input  cke_o,
    output data_o,
    output status
  );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_8_mem.sv
// ============================================================================
// Module      : fifo_mem_512x8
// Description : Simple dual-port RAM, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem_512x8 #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // Array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-address read/write returns the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 8'h00;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_8.sv
// ============================================================================
// Module      : sync_fifo_8
// Description : Single-clock byte FIFO with wrap-bit pointers and level status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_8 #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic         clk,
  input  logic         rst,
  sync_fifo_8_if.slave bus
);

  localparam logic [1:0] c_st_empty = 2'b00;
  localparam logic [1:0] c_st_low   = 2'b01;
  localparam logic [1:0] c_st_half  = 2'b10;
  localparam logic [1:0] c_st_full  = 2'b11;

  localparam logic [AW:0] c_lvl_full = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_lvl_half = (AW+1)'(DEPTH / 2);

  logic [AW-1:0] buf_t;
  logic [AW-1:0] buf_b;
  logic          r_wrap_t;
  logic          r_wrap_b;
  logic [1:0]    r_status;

  logic          beq;
  logic          beq_m;
  logic          w_empty;
  logic          w_full;
  logic          w_do_wr;
  logic          w_do_rd;
  logic [AW:0]   w_ptr_t_nx;
  logic [AW:0]   w_ptr_b_nx;
  logic [AW:0]   w_count_nx;
  logic [1:0]    w_status_nx;
  logic [7:0]    w_rd_data;

  assign beq     = (buf_t == buf_b);
  assign beq_m   = (r_wrap_t == r_wrap_b);
  assign w_empty = beq && beq_m;
  assign w_full  = beq && !beq_m;

  // A write while full proceeds only when a pop frees the slot in the same edge.
  assign w_do_wr = bus.cke && (!w_full || bus.cke_o);
  assign w_do_rd = bus.cke_o && !w_empty;

  assign w_ptr_t_nx = {r_wrap_t, buf_t} + {{AW{1'b0}}, w_do_wr};
  assign w_ptr_b_nx = {r_wrap_b, buf_b} + {{AW{1'b0}}, w_do_rd};
  assign w_count_nx = w_ptr_t_nx - w_ptr_b_nx;

  always_comb begin
    w_status_nx = c_st_low;
    if (w_count_nx == '0) begin
      w_status_nx = c_st_empty;
    end else if (w_count_nx == c_lvl_full) begin
      w_status_nx = c_st_full;
    end else if (w_count_nx >= c_lvl_half) begin
      w_status_nx = c_st_half;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_t    <= '0;
      buf_b    <= '0;
      r_wrap_t <= 1'b0;
      r_wrap_b <= 1'b0;
      r_status <= c_st_empty;
    end else begin
      {r_wrap_t, buf_t} <= w_ptr_t_nx;
      {r_wrap_b, buf_b} <= w_ptr_b_nx;
      r_status          <= w_status_nx;
    end
  end

  fifo_mem_512x8 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_do_wr),
    .i_waddr (buf_t),
    .i_wdata (bus.data),
    .i_re    (w_do_rd),
    .i_raddr (buf_b),
    .o_rdata (w_rd_data)
  );

  assign bus.data_o = w_rd_data;
  assign bus.status = r_status;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_8.sv
// ============================================================================
// Module      : tb_sync_fifo_8
// Description : Directed vector table plus fill/drain sequences for sync_fifo_8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_8;

  logic clk;
  logic rst;

  sync_fifo_8_if bus ();

  sync_fifo_8 #(
    .DEPTH (512),
    .AW    (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cke;
    logic [7:0] data;
    logic       cke_o;
    logic [1:0] exp_status;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [12];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] d, input logic p);
    rst       = r;
    bus.cke   = w;
    bus.data  = d;
    bus.cke_o = p;
  endtask

  function automatic logic [1:0] lvl(input int n);
    if (n == 0)        return 2'b00;
    else if (n >= 512) return 2'b11;
    else if (n >= 256) return 2'b10;
    else               return 2'b01;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    //            rst   cke   data   cke_o status data_o
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 2'b01, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2'b01, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 8'h11};
    vecs[5]  = '{1'b0, 1'b1, 8'h33, 1'b1, 2'b01, 8'h22};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 8'h33};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 8'h33};
    vecs[8]  = '{1'b0, 1'b1, 8'h5C, 1'b1, 2'b01, 8'h33};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 8'h5C};
    vecs[10] = '{1'b1, 1'b1, 8'h77, 1'b1, 2'b00, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 8'h00};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].cke, vecs[i].data, vecs[i].cke_o);
      tick();
      check($sformatf("vec%0d status", i), int'(bus.status), int'(vecs[i].exp_status));
      check($sformatf("vec%0d data_o", i), int'(bus.data_o), int'(vecs[i].exp_data));
    end

    // Reset then idle: empty with both pointer flags set
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("idle status", int'(bus.status), 0);
    check("idle data_o", int'(bus.data_o), 0);
    check("idle beq", int'(dut.beq), 1);
    check("idle beq_m", int'(dut.beq_m), 1);

    // Overfill: 531 writes, the last 19 dropped
    for (int i = 0; i < 531; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0);
      tick();
      check($sformatf("fill%0d status", i), int'(bus.status), int'(lvl(i + 1)));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("full beq", int'(dut.beq), 1);
    check("full beq_m", int'(dut.beq_m), 0);

    // Drain: 0..255 twice, no trace of the dropped bytes
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      check($sformatf("drain%0d data_o", i), int'(bus.data_o), i % 256);
      check($sformatf("drain%0d status", i), int'(bus.status), int'(lvl(511 - i)));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check("empty pop data_o", int'(bus.data_o), 255);
      check("empty pop status", int'(bus.status), 0);
    end

    // Full with simultaneous read/write of 0xAA
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0);
      tick();
    end
    check("refill status", int'(bus.status), 3);
    drive(1'b0, 1'b1, 8'hAA, 1'b1);
    tick();
    check("full rw status", int'(bus.status), 3);
    check("full rw data_o", int'(bus.data_o), 0);
    for (int i = 1; i < 512; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      check($sformatf("post-rw pop%0d", i), int'(bus.data_o), i % 256);
    end
    tick();
    check("0xAA last data_o", int'(bus.data_o), 8'hAA);
    check("0xAA last status", int'(bus.status), 0);

    // Empty with simultaneous read/write of 0x5C
    drive(1'b0, 1'b1, 8'h5C, 1'b1);
    tick();
    check("empty rw status", int'(bus.status), 1);
    check("empty rw data_o", int'(bus.data_o), 8'hAA);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("0x5C pop data_o", int'(bus.data_o), 8'h5C);
    check("0x5C pop status", int'(bus.status), 0);

    // Reset with 300 entries stored
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 8'(i + 1), 1'b0);
      tick();
    end
    check("300 status", int'(bus.status), 2);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    check("mid rst status", int'(bus.status), 0);
    check("mid rst data_o", int'(bus.data_o), 0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("post rst pop data_o", int'(bus.data_o), 0);
    check("post rst pop status", int'(bus.status), 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_8.md
SYNC_FIFO_8 -- requirements
Module: sync_fifo_8

Interface
REQ-001 Parameter DEPTH, default 512, storage entries; SHALL be a power of two (512 fits one iCE40 4 kbit BRAM).
REQ-002 Parameter AW, default 9, pointer address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 cke  input  1  write enable; data written on a clk edge while high.
REQ-006 data  input  8  write data.
REQ-007 cke_o  input  1  read enable; one entry popped on a clk edge while high.
REQ-008 data_o  output  8  registered read data.
REQ-009 status  output  2  fill level: 00 empty, 01 nonempty and below half, 10 half or more but not full, 11 full.
REQ-010 The block SHALL have one clock only; no separate read clock port.

Function
REQ-011 Storage SHALL be a DEPTH x 8 memory, with write pointer buf_t and read pointer buf_b, each AW bits, plus one wrap bit each.
REQ-012 Write: at a rising clk edge with cke=1 and FIFO not full, the block SHALL store data at buf_t and increment buf_t modulo DEPTH.
REQ-013 Read: at a rising clk edge with cke_o=1 and FIFO not empty, the block SHALL load mem[buf_b] into data_o and increment buf_b modulo DEPTH.
REQ-014 Read latency SHALL be one cycle: data_o is valid from the edge that performs the pop.
REQ-015 data_o SHALL hold its last value when no pop occurs, including a read request while empty.
REQ-016 A write while full without a simultaneous read SHALL be discarded; contents and pointers SHALL be unchanged.
REQ-017 Simultaneous read and write when full SHALL perform both; the level stays full.
REQ-018 Simultaneous read and write when empty SHALL perform only the write; data_o is unchanged.
REQ-019 Simultaneous read and write otherwise SHALL perform both; the count is unchanged.
REQ-020 Pointer-equality flag beq SHALL equal (buf_t == buf_b), excluding the wrap bits.
REQ-021 Wrap-match flag beq_m SHALL be true when the wrap bits are equal.
REQ-022 Empty SHALL be beq && beq_m; full SHALL be beq && !beq_m.
REQ-023 Count SHALL be the write pointer minus the read pointer, computed at (AW+1)-bit width.
REQ-024 status SHALL be registered and updated on every edge from the post-update count, so it is coherent with the pointers after that edge.
REQ-025 Pointer wrap-around SHALL be seamless: addresses go DEPTH-1 -> 0 and the wrap bit toggles.

Reset
REQ-026 While rst=1 at an edge, the block SHALL clear buf_t, buf_b and both wrap bits, and set data_o=0 and status=00.
REQ-027 rst SHALL take priority over cke and cke_o in the same cycle.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-operation SHALL discard all stored entries.

Structure
REQ-030 No shared package is required; the status encodings 00/01/10/11 SHALL be local constants.
REQ-031 The memory SHALL be a sub-module, fifo_mem_512x8, with a synchronous write port and a registered read port, inferable as SB_RAM40_4K.
REQ-032 Pointer and status logic SHALL reside in sync_fifo_8.

Verification
REQ-033 Reset, then idle -> status=00, data_o=0, beq=1, beq_m=1.
REQ-034 Write bytes 0..530 (8-bit truncated) with cke pulses and no reads -> status 01 after the first write, 10 from the 256th write, 11 after the 512th write; writes 513..531 are dropped.
REQ-035 Then pop continuously -> data_o sequence 0..255, 0..255 (512 values); status returns to 00; further pops leave data_o=255.
REQ-036 Fill to 512, then perform a simultaneous read and write of 0xAA -> status stays 11 and data_o equals the oldest entry; 0xAA is read last.
REQ-037 Empty FIFO with simultaneous read and write of 0x5C -> status 01; data_o is unchanged; the next pop yields 0x5C.
REQ-038 Assert rst with 300 entries stored -> next cycle status=00; a pop leaves data_o=0.
